// File: rtl/pattern_serializer.sv
// Purpose: serialises a captured WIDTH-bit pattern MSB first, repeat_in+1 times, GAP idle cycles apart.
// Latency: first (MSB) bit appears the cycle after start is sampled in IDLE; done pulses the cycle after the last LSB.
// Backpressure: none; start is only honoured in IDLE and is ignored while a transfer is in progress.
//
// Ports:
//   clk, rst           - single clock, asynchronous active-high reset
//   start              - launch request, sampled only in IDLE
//   pattern_in         - pattern to send, MSB first (captured at start)
//   repeat_in          - extra repetitions, total frames = repeat_in+1 (captured at start)
//   data_out           - serial bit stream
//   data_valid         - data_out carries a pattern bit this cycle
//   frame_start        - high with the MSB of every frame
//   busy               - transfer in progress
//   done               - one-cycle pulse after the final bit
module pattern_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_in,
    output logic             data_out,
    output logic             data_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LAST);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP_WAIT,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   pattern_q;   // captured copy, reloaded for every repetition
    logic [WIDTH-1:0]   shift_reg;   // bits still to be sent in the current frame, MSB aligned
    logic [BW-1:0]      bit_cnt;     // index of the bit currently on data_out
    logic [CNT_W-1:0]   frame_cnt;   // repetitions still owed after the current frame
    logic [GAP_W-1:0]   gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pattern_q   <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            gap_cnt     <= '0;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // The MSB goes straight to the output register so it is
                        // visible the cycle after start; the rest waits in shift_reg.
                        pattern_q   <= pattern_in;
                        frame_cnt   <= repeat_in;
                        shift_reg   <= pattern_in << 1;
                        data_out    <= pattern_in[WIDTH-1];
                        data_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_cnt != LAST_BIT) begin
                        bit_cnt     <= bit_cnt + BW'(1);
                        data_out    <= shift_reg[WIDTH-1];
                        shift_reg   <= shift_reg << 1;
                        frame_start <= 1'b0;
                    end else begin
                        // LSB is on the output now: decide what follows it.
                        bit_cnt <= '0;
                        if (frame_cnt != '0) begin
                            frame_cnt <= frame_cnt - CNT_W'(1);
                            if (GAP > 0) begin
                                state       <= GAP_WAIT;
                                gap_cnt     <= GAP_INIT;
                                data_out    <= 1'b0;
                                data_valid  <= 1'b0;
                                frame_start <= 1'b0;
                            end else begin
                                shift_reg   <= pattern_q << 1;
                                data_out    <= pattern_q[WIDTH-1];
                                data_valid  <= 1'b1;
                                frame_start <= 1'b1;
                            end
                        end else begin
                            state       <= DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            data_out    <= 1'b0;
                            data_valid  <= 1'b0;
                            frame_start <= 1'b0;
                        end
                    end
                end

                GAP_WAIT: begin
                    if (gap_cnt == '0) begin
                        state       <= SHIFT;
                        shift_reg   <= pattern_q << 1;
                        data_out    <= pattern_q[WIDTH-1];
                        data_valid  <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
module tb_pattern_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start0;
    logic [7:0] pat1, pat0;
    logic [3:0] rep1, rep0;
    logic       d1, v1, fs1, b1, dn1;
    logic       d0, v0, fs0, b0, dn0;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    pattern_serializer #(.WIDTH(8), .CNT_W(4), .GAP(1)) u_gap1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .pattern_in (pat1),
        .repeat_in  (rep1),
        .data_out   (d1),
        .data_valid (v1),
        .frame_start(fs1),
        .busy       (b1),
        .done       (dn1)
    );

    pattern_serializer #(.WIDTH(8), .CNT_W(4), .GAP(0)) u_gap0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .pattern_in (pat0),
        .repeat_in  (rep0),
        .data_out   (d0),
        .data_valid (v0),
        .frame_start(fs0),
        .busy       (b0),
        .done       (dn0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output vector order: {data_out, data_valid, frame_start, busy, done}
    function automatic logic [4:0] outs(input bit gz);
        return gz ? {d0, v0, fs0, b0, dn0} : {d1, v1, fs1, b1, dn1};
    endfunction

    // Launches one transfer and checks every cycle against the expected stream:
    // frames of 8 bits MSB first, g idle cycles between frames, done right after.
    task automatic run_xfer(input bit gz, input logic [7:0] p, input logic [3:0] r,
                            input bit inject, input int exp_busy, input int exp_fs,
                            input string name, output int det);
        int g;
        int frame_len;
        int total;
        int pos;
        int busy_n;
        int fs_n;
        int done_n;
        logic [3:0] sh;
        logic [4:0] expv;
        logic [4:0] obs;
        g         = gz ? 0 : 1;
        frame_len = 8 + g;
        total     = (int'(r) + 1) * 8 + int'(r) * g;
        busy_n    = 0;
        fs_n      = 0;
        done_n    = 0;
        det       = 0;
        sh        = 4'b0000;
        if (gz) begin start0 = 1'b1; pat0 = p; rep0 = r; end
        else    begin start1 = 1'b1; pat1 = p; rep1 = r; end
        for (int k = 0; k <= total + 2; k++) begin
            tick();
            if (k == 0) begin
                if (gz) start0 = 1'b0; else start1 = 1'b0;
            end
            if (k < total) begin
                pos = k % frame_len;
                if (pos < 8) expv = {p[7 - pos], 1'b1, (pos == 0), 1'b1, 1'b0};
                else         expv = 5'b00010;
            end else if (k == total) begin
                expv = 5'b00001;
            end else begin
                expv = 5'b00000;
            end
            obs = outs(gz);
            check($sformatf("%s_k%0d", name, k), {27'd0, obs}, {27'd0, expv});
            if (obs[1]) busy_n++;
            if (obs[2]) fs_n++;
            if (obs[0]) done_n++;
            if (obs[3]) begin
                sh = {sh[2:0], obs[4]};
                if (sh == 4'b1010) det++;
            end
            if (inject && !gz) begin
                if (k == 2) begin start1 = 1'b1; pat1 = 8'hFF; rep1 = 4'd3; end
                if (k == 3) start1 = 1'b0;
                if (k == total) start1 = 1'b1;
                if (k == total + 1) start1 = 1'b0;
            end
        end
        check({name, "_busy_cycles"}, busy_n, exp_busy);
        check({name, "_frame_starts"}, fs_n, exp_fs);
        check({name, "_done_pulses"}, done_n, 1);
    endtask

    initial begin
        int det;
        // Reset held with start asserted: nothing may launch.
        rst    = 1'b1;
        start1 = 1'b1; pat1 = 8'hAA; rep1 = 4'd0;
        start0 = 1'b1; pat0 = 8'hAA; rep0 = 4'd0;
        #1;
        check("reset_t0_gap1", {27'd0, outs(1'b0)}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_gap1_c%0d", i), {27'd0, outs(1'b0)}, 0);
            check($sformatf("reset_gap0_c%0d", i), {27'd0, outs(1'b1)}, 0);
        end
        rst = 1'b0; start1 = 1'b0; start0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("post_reset_idle_c%0d", i), {27'd0, outs(1'b0)}, 0);
        end

        // Single frame of 1010_1010; detector sees 1010 three times (overlapping).
        run_xfer(1'b0, 8'b1010_1010, 4'd0, 1'b0, 8, 1, "single", det);
        check("single_detector_hits", det, 3);

        // Three frames of F0 separated by one idle cycle: 3*8 + 2*1 = 26 busy cycles.
        run_xfer(1'b0, 8'hF0, 4'd2, 1'b0, 26, 3, "repeat", det);

        // GAP=0: two frames of 5A back to back, 16 contiguous valid bits.
        run_xfer(1'b1, 8'h5A, 4'd1, 1'b0, 16, 2, "b2b", det);

        // start/pattern/repeat changes during the transfer and during done are ignored.
        run_xfer(1'b0, 8'h3C, 4'd0, 1'b1, 8, 1, "ignore", det);
        pat1 = 8'hAA; rep1 = 4'd0;

        // Mid-transfer reset: assert during bit 4, between clock edges.
        start1 = 1'b1; pat1 = 8'hC3; rep1 = 4'd1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        check("midrst_bit4_valid", {31'd0, v1}, 1);
        check("midrst_bit4_data", {31'd0, d1}, 0);
        #5;
        rst = 1'b1;
        #1;
        check("midrst_async_clear", {27'd0, outs(1'b0)}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst_held_c%0d", i), {27'd0, outs(1'b0)}, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("midrst_idle_c%0d", i), {27'd0, outs(1'b0)}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
